// File: rtl/data_sram_responder.sv
// Local data SRAM behind the core's we/addr/wdata request port: windowed decode, read-first, 1-cycle read latency.
// Define DSRAM_CLEAR_EN to zero the whole array after every reset before ready rises.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic        sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        ready,
    input  logic        err_clr,
    output logic        err_oor,
    output logic        err_misalign,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef DSRAM_CLEAR_EN
    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ST_READY = 1'b0} state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [31:0]         r_rdata;
    logic [31:0]         r_rd_cnt;
    logic [31:0]         r_wr_cnt;
    logic                r_err_oor;
    logic                r_err_mis;
    logic [31:0]         r_mem [DEPTH];

    logic                w_acc;
    logic                w_inwin;
    logic                w_mis;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_idx;
    logic [31:0]         w_mem_wdata;

    assign w_inwin = (sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_mis   = |sram_addr[1:0];
    assign w_idx   = sram_addr[ADDR_W+1:2];
    assign w_acc   = r_ready & sram_en & ~reset;

`ifdef DSRAM_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_idx;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_CLEAR;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)                  r_clr_idx <= '0;
        else if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && r_clr_idx == {ADDR_W{1'b1}})
            w_state_nxt = ST_READY;
    end

    // The sweep owns the write port while clearing; no access can be accepted then.
    always_comb begin
        w_ready_nxt = (w_state_nxt == ST_READY);
        w_mem_we    = w_acc & sram_we & w_inwin & ~w_mis;
        w_mem_idx   = w_idx;
        w_mem_wdata = sram_wdata;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = ~reset;
            w_mem_idx   = r_clr_idx;
            w_mem_wdata = '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_READY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == ST_READY);
        w_mem_we    = w_acc & sram_we & w_inwin & ~w_mis;
        w_mem_idx   = w_idx;
        w_mem_wdata = sram_wdata;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_ready <= 1'b0;
        else       r_ready <= w_ready_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
    end

    // Read-first: a write also returns the word it overwrites.
    always_ff @(posedge clk) begin
        if (reset)      r_rdata <= '0;
        else if (w_acc) r_rdata <= w_inwin ? r_mem[w_idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_acc) begin
            if (sram_we) r_wr_cnt <= r_wr_cnt + 32'd1;
            else         r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_oor <= 1'b0;
            r_err_mis <= 1'b0;
        end else begin
            if (w_acc & ~w_inwin) r_err_oor <= 1'b1;
            else if (err_clr)     r_err_oor <= 1'b0;
            if (w_acc & w_mis)    r_err_mis <= 1'b1;
            else if (err_clr)     r_err_mis <= 1'b0;
        end
    end

    assign sram_rdata   = r_rdata;
    assign ready        = r_ready;
    assign err_oor      = r_err_oor;
    assign err_misalign = r_err_mis;
    assign rd_cnt       = r_rd_cnt;
    assign wr_cnt       = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized self-checking bench for data_sram_responder against an array-based reference model.
module tb_data_sram_responder;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1c00_0000;
`ifdef DSRAM_CLEAR_EN
    localparam int          EXP_LAT = 16;
`else
    localparam int          EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_en = 1'b0;
    logic        sram_we = 1'b0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_wdata = '0;
    logic        err_clr = 1'b0;
    logic [31:0] sram_rdata;
    logic        ready;
    logic        err_oor;
    logic        err_misalign;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    data_sram_responder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .ready(ready), .err_clr(err_clr), .err_oor(err_oor), .err_misalign(err_misalign),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [31:0] m_rdata;
    bit          m_rknown;
    logic [31:0] m_rd, m_wr;
    bit          m_oor, m_mis;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic reset_model();
        m_rd = 0; m_wr = 0; m_oor = 0; m_mis = 0; m_rdata = 0; m_rknown = 1;
`ifdef DSRAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_vld[i] = 1; end
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
    task automatic step(input bit en, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit clr);
        int idx;
        bit inw, mis;
        idx = (addr >> 2) % DEPTH;
        inw = (addr >> (AW + 2)) == (BASE >> (AW + 2));
        mis = (addr % 4) != 0;
        sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata; err_clr = clr;
        if (en) begin
            if (we) begin
                m_wr = m_wr + 1;
                if (inw && !mis) begin
                    m_rdata = m_mem[idx]; m_rknown = m_vld[idx];
                    m_mem[idx] = wdata;   m_vld[idx] = 1;
                end else begin
                    m_rknown = 0;
                end
            end else begin
                m_rd = m_rd + 1;
                if (inw) begin m_rdata = m_mem[idx]; m_rknown = m_vld[idx]; end
                else     begin m_rdata = 0;          m_rknown = 1;          end
            end
            m_oor = !inw ? 1 : (clr ? 0 : m_oor);
            m_mis = mis  ? 1 : (clr ? 0 : m_mis);
        end else if (clr) begin
            m_oor = 0; m_mis = 0;
        end
        @(posedge clk); #1;
        sram_en = 0; sram_we = 0; err_clr = 0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        int lat;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", ready); end
        n_cmp++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", sram_rdata); end
        n_cmp++; if ({err_oor, err_misalign} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b expected 00", {err_oor, err_misalign}); end
        n_cmp++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", rd_cnt, wr_cnt); end
        reset = 0;
        reset_model();
        wait_ready(lat);
        n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL ready_latency: got %0d expected %0d", lat, EXP_LAT); end
    endtask

    task automatic test_write_read();
        step(1, 1, 32'h1c00_0010, 32'hDEAD_BEEF, 0);
        step(1, 0, 32'h1c00_0010, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h expected deadbeef", sram_rdata); end
        n_cmp++; if (wr_cnt !== 32'd1) begin n_fail++; $display("FAIL wr_rd_wrcnt: got %0d expected 1", wr_cnt); end
        n_cmp++; if (rd_cnt !== 32'd1) begin n_fail++; $display("FAIL wr_rd_rdcnt: got %0d expected 1", rd_cnt); end
        step(0, 0, 32'h1c00_0000, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_hold: got %h expected deadbeef", sram_rdata); end
        n_cmp++; if (rd_cnt !== 32'd1) begin n_fail++; $display("FAIL idle_rdcnt: got %0d expected 1", rd_cnt); end
    endtask

    task automatic test_clear_sweep();
`ifdef DSRAM_CLEAR_EN
        step(1, 0, 32'h1c00_0008, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL clear_read: got %h expected 0", sram_rdata); end
`endif
    endtask

    task automatic test_read_first();
        step(1, 1, 32'h1c00_0004, 32'h1111_1111, 0);
        step(1, 1, 32'h1c00_0004, 32'h2222_2222, 0);
        n_cmp++; if (sram_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL read_first_old: got %h expected 11111111", sram_rdata); end
        step(1, 0, 32'h1c00_0004, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL read_first_new: got %h expected 22222222", sram_rdata); end
    endtask

    task automatic test_out_of_window();
        step(1, 1, 32'h1c00_0000, 32'hA5A5_0000, 0);
        step(1, 1, 32'h1d00_0000, 32'hFFFF_FFFF, 0);
        n_cmp++; if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_wr_flag: got %b expected 1", err_oor); end
        step(1, 0, 32'h1d00_0000, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rd_data: got %h expected 0", sram_rdata); end
        step(1, 0, 32'h1c00_0000, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'hA5A5_0000) begin n_fail++; $display("FAIL oor_mem_kept: got %h expected a5a50000", sram_rdata); end
        step(0, 0, 32'h0, 32'h0, 1);
        n_cmp++; if (err_oor !== 1'b0) begin n_fail++; $display("FAIL oor_clr: got %b expected 0", err_oor); end
        step(1, 0, 32'h1d00_0000, 32'h0, 1);
        n_cmp++; if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_set_wins: got %b expected 1", err_oor); end
        n_cmp++; if (wr_cnt !== m_wr || rd_cnt !== m_rd) begin n_fail++; $display("FAIL oor_cnt: got %0d/%0d expected %0d/%0d", wr_cnt, rd_cnt, m_wr, m_rd); end
        step(0, 0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_misaligned();
        step(1, 1, 32'h1c00_0006, 32'h3333_3333, 0);
        n_cmp++; if (err_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", err_misalign); end
        n_cmp++; if (err_oor !== 1'b0) begin n_fail++; $display("FAIL mis_no_oor: got %b expected 0", err_oor); end
        step(1, 0, 32'h1c00_0006, 32'h0, 0);
        n_cmp++; if (sram_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL mis_read: got %h expected 22222222", sram_rdata); end
        step(0, 0, 32'h0, 32'h0, 1);
        n_cmp++; if (err_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clr: got %b expected 0", err_misalign); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit en, we, clr;
        for (int i = 0; i < DEPTH; i++) step(1, 1, BASE + 32'(i * 4), $urandom, 0);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE ^ (32'h1 << $urandom_range(AW + 2, 31));
                1:       a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            en  = $urandom_range(0, 7) != 0;
            we  = $urandom_range(0, 1) != 0;
            clr = $urandom_range(0, 11) == 0;
            step(en, we, a, $urandom, clr);
            if (m_rknown) begin
                n_cmp++; if (sram_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, sram_rdata, m_rdata); end
            end
            n_cmp++; if (err_oor !== m_oor) begin n_fail++; $display("FAIL rand_oor[%0d]: got %b expected %b", n, err_oor, m_oor); end
            n_cmp++; if (err_misalign !== m_mis) begin n_fail++; $display("FAIL rand_mis[%0d]: got %b expected %b", n, err_misalign, m_mis); end
            n_cmp++; if (rd_cnt !== m_rd || wr_cnt !== m_wr) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, rd_cnt, wr_cnt, m_rd, m_wr); end
        end
    endtask

    task automatic test_reset_again();
        int lat;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
`ifdef DSRAM_CLEAR_EN
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midclr_ready: got %b expected 0", ready); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        n_cmp++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL midclr_cnt: got %0d/%0d expected 0/0", rd_cnt, wr_cnt); end
`endif
        reset_model();
        wait_ready(lat);
        n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL reset_again_latency: got %0d expected %0d", lat, EXP_LAT); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, BASE + 32'(i * 4), 32'h0, 0);
            if (m_rknown) begin
                n_cmp++; if (sram_rdata !== m_rdata) begin n_fail++; $display("FAIL reset_again_mem[%0d]: got %h expected %h", i, sram_rdata, m_rdata); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 'x; m_vld[i] = 0; end
        test_reset();
        test_write_read();
        test_clear_sweep();
        test_read_first();
        test_out_of_window();
        test_misaligned();
        test_random();
        test_reset_again();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
